uart_rx_frontend: RTL and testbench

Serial receive front end for the pipelined CPU's UART peripheral. It synchronises the asynchronous `UART_RX` pin and decodes 8N1 frames, LSB first, at a fixed bit period. Each byte is held in a one-entry buffer with a valid/ack handshake toward the CPU's memory-mapped UART register. Framing and overrun errors are reported as sticky flags.

---
 rtl/uart_rx_frontend_if.sv | 30 +++
 rtl/uart_rx_frontend.sv | 150 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frontend_if.sv
// Byte-side handshake and status bundle between the UART receive front end and the CPU register.
interface uart_rx_frontend_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       err_clr;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ack,
    input  err_clr
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ack,
    output err_clr
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a one-byte
// valid/ack buffer with sticky framing and overrun flags.
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               UART_RX,
  uart_rx_frontend_if.master rx_if
);

  localparam int unsigned H     = CLKS_PER_BIT / 2;
  localparam int          CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rx_s1_q, rx_sync_q, rx_prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;
  logic             stop_done;
  logic             stop_ok, stop_bad, load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    stop_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A falling edge is required, so a held-low line cannot retrigger.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d[bit_idx_q] = rx_sync_q;
          cnt_d              = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          stop_done = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An ack arriving with a new byte frees the slot in the same cycle, so no overrun.
  always_comb begin
    stop_ok     = stop_done & rx_sync_q;
    stop_bad    = stop_done & ~rx_sync_q;
    load        = stop_ok & (~rx_valid_q | rx_if.rx_ack);
    rx_data_d   = load ? shreg_q : rx_data_q;
    rx_valid_d  = rx_valid_q;
    if (load) begin
      rx_valid_d = 1'b1;
    end else if (rx_if.rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
    overrun_d   = overrun_q;
    if (stop_ok && rx_valid_q && !rx_if.rx_ack) begin
      overrun_d = 1'b1;
    end else if (rx_if.err_clr) begin
      overrun_d = 1'b0;
    end
    frame_err_d = frame_err_q;
    if (stop_bad) begin
      frame_err_d = 1'b1;
    end else if (rx_if.err_clr) begin
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_s1_q     <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_s1_q     <= UART_RX;
      rx_sync_q   <= rx_s1_q;
      rx_prev_q   <= rx_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed scenarios plus randomized frames
// checked against a byte-level buffer/flag model.
module tb_uart_rx_frontend;
  localparam int C   = 16;
  localparam int H   = C / 2;
  localparam int LAT = 2 + H + 9 * C + 1;

  logic sysclk = 1'b0;
  logic reset;
  logic UART_RX;
  int   checks = 0;
  int   passed = 0;

  logic [7:0] m_data;
  bit         m_valid, m_ferr, m_ovr;

  uart_rx_frontend_if rx_if ();

  uart_rx_frontend #(.CLKS_PER_BIT(C)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .UART_RX(UART_RX),
    .rx_if  (rx_if)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_data = 8'h00; m_valid = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good)        m_ferr = 1;
    else if (m_valid) m_ovr = 1;
    else begin m_data = b; m_valid = 1; end
  endtask

  task automatic send_bits(input logic lvl, input int n);
    UART_RX = lvl;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    send_bits(1'b0, C);
    for (int i = 0; i < 8; i++) send_bits(b[i], C);
    send_bits(stop_lvl, C);
  endtask

  task automatic do_reset();
    reset = 1'b1; UART_RX = 1'b1; rx_if.rx_ack = 1'b0; rx_if.err_clr = 1'b0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    model_reset();
  endtask

  task automatic pulse_ack();
    rx_if.rx_ack = 1'b1; @(negedge sysclk); rx_if.rx_ack = 1'b0;
  endtask

  task automatic pulse_err_clr();
    rx_if.err_clr = 1'b1; @(negedge sysclk); rx_if.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    repeat (2) @(negedge sysclk);
    obs = {rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun, rx_if.busy};
    checks++;
    if (obs !== 12'h000) $display("FAIL reset_state: got %h expected 000", obs);
    else passed++;
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    model_reset();
  endtask

  task automatic test_single_byte();
    int  lat = 0;
    bit  seen = 0;
    fork
      begin send_frame(8'h18, 1'b1); UART_RX = 1'b1; end
      begin
        while (!seen && lat < 400) begin
          @(posedge sysclk); lat++; #1; seen = rx_if.rx_valid;
        end
      end
    join
    checks++;
    if (!seen || lat < LAT - 1 || lat > LAT + 1)
      $display("FAIL single_latency: got %0d cycles (seen=%0d) expected %0d+-1", lat, seen, LAT);
    else passed++;
    model_frame(8'h18, 1);
    checks++;
    if (rx_if.rx_data !== m_data) $display("FAIL single_data: got %h expected %h", rx_if.rx_data, m_data);
    else passed++;
    checks++;
    if ({rx_if.frame_err, rx_if.overrun, rx_if.busy} !== 3'b000)
      $display("FAIL single_flags_busy: got %b expected 000", {rx_if.frame_err, rx_if.overrun, rx_if.busy});
    else passed++;
    pulse_ack(); m_valid = 0;
    checks++;
    if (rx_if.rx_valid !== 1'b0) $display("FAIL single_ack_clear: got %b expected 0", rx_if.rx_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [2];
    exp_b[0] = 8'h18; exp_b[1] = 8'h78;
    fork
      begin send_frame(exp_b[0], 1'b1); send_frame(exp_b[1], 1'b1); UART_RX = 1'b1; end
      begin
        for (int k = 0; k < 2; k++) begin
          int n = 0;
          while (!rx_if.rx_valid && n < 400) begin @(posedge sysclk); #1; n++; end
          checks++;
          if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== exp_b[k])
            $display("FAIL b2b_byte%0d: got %h valid=%b expected %h valid=1", k, rx_if.rx_data, rx_if.rx_valid, exp_b[k]);
          else passed++;
          @(negedge sysclk); rx_if.rx_ack = 1'b1;
          @(negedge sysclk); rx_if.rx_ack = 1'b0;
        end
      end
    join
    checks++;
    if ({rx_if.overrun, rx_if.frame_err, rx_if.rx_valid} !== 3'b000)
      $display("FAIL b2b_flags: got %b expected 000", {rx_if.overrun, rx_if.frame_err, rx_if.rx_valid});
    else passed++;
  endtask

  task automatic test_no_ack();
    do_reset();
    send_frame(8'h18, 1'b1);
    send_frame(8'h78, 1'b1);
    UART_RX = 1'b1;
    model_frame(8'h18, 1); model_frame(8'h78, 1);
    checks++;
    if ({rx_if.rx_data, rx_if.rx_valid, rx_if.overrun, rx_if.frame_err} !== {m_data, m_valid, m_ovr, m_ferr})
      $display("FAIL noack_overrun: got %h/%b/%b/%b expected %h/%b/%b/%b", rx_if.rx_data, rx_if.rx_valid,
               rx_if.overrun, rx_if.frame_err, m_data, m_valid, m_ovr, m_ferr);
    else passed++;
    pulse_err_clr(); m_ovr = 0; m_ferr = 0;
    checks++;
    if ({rx_if.overrun, rx_if.rx_valid} !== {m_ovr, m_valid})
      $display("FAIL noack_err_clr: got ovr=%b valid=%b expected ovr=%b valid=%b",
               rx_if.overrun, rx_if.rx_valid, m_ovr, m_valid);
    else passed++;
  endtask

  task automatic test_ack_collision();
    // Buffer is still full here; the ack lands on the very edge that loads the new byte.
    fork
      begin send_frame(8'h5A, 1'b1); UART_RX = 1'b1; end
      begin
        repeat (LAT - 1) @(negedge sysclk);
        rx_if.rx_ack = 1'b1;
        @(negedge sysclk);
        rx_if.rx_ack = 1'b0;
      end
    join
    checks++;
    if ({rx_if.rx_data, rx_if.rx_valid, rx_if.overrun} !== {8'h5A, 1'b1, 1'b0})
      $display("FAIL ack_collision: got %h/%b/%b expected 5a/1/0", rx_if.rx_data, rx_if.rx_valid, rx_if.overrun);
    else passed++;
  endtask

  task automatic test_frame_error();
    bit retrig = 0;
    do_reset();
    send_frame(8'h55, 1'b0);
    UART_RX = 1'b0;
    for (int i = 0; i < 2 * C; i++) begin
      @(negedge sysclk);
      if (rx_if.busy) retrig = 1;
    end
    model_frame(8'h55, 0);
    checks++;
    if (retrig !== 1'b0) $display("FAIL ferr_no_retrigger: got busy=%b expected 0", retrig);
    else passed++;
    checks++;
    if ({rx_if.frame_err, rx_if.rx_valid} !== {m_ferr, m_valid})
      $display("FAIL ferr_flag: got ferr=%b valid=%b expected ferr=%b valid=%b",
               rx_if.frame_err, rx_if.rx_valid, m_ferr, m_valid);
    else passed++;
    send_bits(1'b1, 2 * C);
    send_frame(8'hA3, 1'b1);
    UART_RX = 1'b1;
    model_frame(8'hA3, 1);
    checks++;
    if ({rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err} !== {m_data, m_valid, m_ferr})
      $display("FAIL ferr_recover: got %h/%b/%b expected %h/%b/%b", rx_if.rx_data, rx_if.rx_valid,
               rx_if.frame_err, m_data, m_valid, m_ferr);
    else passed++;
  endtask

  task automatic test_glitch();
    bit saw_busy = 0;
    do_reset();
    UART_RX = 1'b0;
    for (int i = 0; i < H + 3; i++) begin
      if (i == 4) UART_RX = 1'b1;
      @(negedge sysclk);
      if (rx_if.busy) saw_busy = 1;
    end
    checks++;
    if ({saw_busy, rx_if.busy} !== 2'b10)
      $display("FAIL glitch_busy: got seen=%b now=%b expected seen=1 now=0", saw_busy, rx_if.busy);
    else passed++;
    repeat (4 * C) @(negedge sysclk);
    checks++;
    if ({rx_if.rx_valid, rx_if.frame_err, rx_if.overrun} !== 3'b000)
      $display("FAIL glitch_quiet: got %b expected 000", {rx_if.rx_valid, rx_if.frame_err, rx_if.overrun});
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  b = 8'hC3;
    logic [11:0] obs;
    do_reset();
    send_frame(8'h18, 1'b1);
    UART_RX = 1'b1;
    send_bits(1'b0, C);
    for (int i = 0; i < 4; i++) send_bits(b[i], C);
    send_bits(b[4], C / 2);
    checks++;
    if ({rx_if.busy, rx_if.rx_valid} !== 2'b11)
      $display("FAIL midreset_pre: got busy=%b valid=%b expected 1/1", rx_if.busy, rx_if.rx_valid);
    else passed++;
    reset = 1'b1;
    #1;
    obs = {rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun, rx_if.busy};
    checks++;
    if (obs !== 12'h000) $display("FAIL midreset_async: got %h expected 000", obs);
    else passed++;
    UART_RX = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    model_reset();
    send_bits(1'b1, 2 * C);
    send_frame(8'h3C, 1'b1);
    UART_RX = 1'b1;
    model_frame(8'h3C, 1);
    checks++;
    if ({rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun} !== {m_data, m_valid, m_ferr, m_ovr})
      $display("FAIL midreset_next: got %h/%b/%b/%b expected %h/%b/%b/%b", rx_if.rx_data, rx_if.rx_valid,
               rx_if.frame_err, rx_if.overrun, m_data, m_valid, m_ferr, m_ovr);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 14; it++) begin
      logic [7:0] b;
      bit         good;
      int         act;
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good ? 1'b1 : 1'b0);
      if (!good) send_bits(1'b0, $urandom_range(0, C));
      UART_RX = 1'b1;
      model_frame(b, good);
      checks++;
      if ({rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun} !== {m_data, m_valid, m_ferr, m_ovr})
        $display("FAIL random_frame%0d: got %h/%b/%b/%b expected %h/%b/%b/%b (sent %h good=%0d)", it,
                 rx_if.rx_data, rx_if.rx_valid, rx_if.frame_err, rx_if.overrun,
                 m_data, m_valid, m_ferr, m_ovr, b, good);
      else passed++;
      act = $urandom_range(0, 3);
      if (act == 0) begin pulse_ack(); m_valid = 0; end
      else if (act == 1) begin pulse_err_clr(); m_ferr = 0; m_ovr = 0; end
      send_bits(1'b1, $urandom_range(1, C));
    end
  endtask

  initial begin
    reset = 1'b1; UART_RX = 1'b1; rx_if.rx_ack = 1'b0; rx_if.err_clr = 1'b0;
    model_reset();
    @(negedge sysclk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_no_ack();
    test_ack_collision();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
